hack_cpu: RTL and testbench

Hack CPU core that decodes 16-bit Hack instructions into `alu` control words and owns the A, D and PC registers. It is the control-side counterpart to the `alu` block: the ALU computes, and this block decides each cycle what the ALU sees and where the result goes. It sits between instruction ROM and data RAM in the Hack computer top level. It retires at most one instruction per clock, gated by `instr_valid`.

---
 rtl/hack_pkg.sv | 20 ++
 rtl/alu.sv | 34 +++
 rtl/hack_cpu.sv | 121 ++++++++++++
 tb/tb_hack_cpu.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared Hack instruction field positions and the comp encodings used
// when building instruction words.
package hack_pkg;

    localparam int A_BIT    = 15;
    localparam int ABIT_M   = 12;
    localparam int COMP_LSB = 6;
    localparam int DEST_A   = 5;
    localparam int DEST_D   = 4;
    localparam int DEST_M   = 3;
    localparam int JLT      = 2;
    localparam int JEQ      = 1;
    localparam int JGT      = 0;

    localparam logic [5:0] COMP_ZERO   = 6'b101010;
    localparam logic [5:0] COMP_ONE    = 6'b111111;
    localparam logic [5:0] COMP_X      = 6'b001100;
    localparam logic [5:0] COMP_XPLUSY = 6'b000010;

endpackage

// File: rtl/alu.sv
// Hack ALU: optional zero/negate on each operand, add or AND, optional
// negate of the result, plus zero and negative flags.
module alu (
    input  logic [15:0] i_x,
    input  logic [15:0] i_y,
    input  logic        i_zx,
    input  logic        i_nx,
    input  logic        i_zy,
    input  logic        i_ny,
    input  logic        i_f,
    input  logic        i_no,
    output logic [15:0] o_out,
    output logic        o_zr,
    output logic        o_ng
);

    logic [15:0] w_x;
    logic [15:0] w_y;
    logic [15:0] w_f;

    // Operand preconditioning, function select and output negation.
    always_comb begin
        w_x   = i_zx ? 16'h0000 : i_x;
        w_x   = i_nx ? ~w_x : w_x;
        w_y   = i_zy ? 16'h0000 : i_y;
        w_y   = i_ny ? ~w_y : w_y;
        w_f   = i_f ? (w_x + w_y) : (w_x & w_y);
        o_out = i_no ? ~w_f : w_f;
    end

    assign o_zr = (o_out == 16'h0000);
    assign o_ng = o_out[15];

endmodule

// File: rtl/hack_cpu.sv
// Hack CPU core: instruction decode, A/D/PC registers, jump logic and a
// retired-instruction counter around the Hack ALU.
// Optional feature macro: HACK_CPU_HALT_EN adds a sticky `halted` output
// that freezes the core once a taken jump targets its own address.
module hack_cpu
    import hack_pkg::*;
#(
    parameter int PC_W  = 15,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      instr,
    input  logic             instr_valid,
    input  logic [15:0]      inM,
    output logic [15:0]      outM,
    output logic             writeM,
    output logic [PC_W-1:0]  addressM,
    output logic [PC_W-1:0]  pc,
    output logic [CNT_W-1:0] retired
`ifdef HACK_CPU_HALT_EN
    ,
    output logic             halted
`endif
);

    localparam logic [PC_W-1:0]  PC_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [15:0]      r_a;
    logic [15:0]      r_d;
    logic [PC_W-1:0]  r_pc;
    logic [CNT_W-1:0] r_retired;

    logic             w_is_c;
    logic             w_fire;
    logic             w_halt_blk;
    logic [15:0]      w_alu_y;
    logic [15:0]      w_alu_out;
    logic             w_zr;
    logic             w_ng;
    logic             w_jump;
    logic             w_load_a;
    logic             w_load_d;
    logic [15:0]      w_a_nxt;
    logic [PC_W-1:0]  w_pc_nxt;
    logic             w_unused_bits;

    // Bits 14:13 of a C-instruction carry no meaning.
    assign w_unused_bits = &{1'b0, instr[14:13]};

    assign w_is_c  = instr[A_BIT];
    assign w_fire  = instr_valid & ~w_halt_blk;
    assign w_alu_y = instr[ABIT_M] ? inM : r_a;

    alu u_alu (
        .i_x   (r_d),
        .i_y   (w_alu_y),
        .i_zx  (instr[COMP_LSB+5]),
        .i_nx  (instr[COMP_LSB+4]),
        .i_zy  (instr[COMP_LSB+3]),
        .i_ny  (instr[COMP_LSB+2]),
        .i_f   (instr[COMP_LSB+1]),
        .i_no  (instr[COMP_LSB]),
        .o_out (w_alu_out),
        .o_zr  (w_zr),
        .o_ng  (w_ng)
    );

    // Decode: destinations, jump condition and next-state values. Jump
    // target and data address always use A from before this instruction.
    always_comb begin
        w_jump   = w_is_c & ((instr[JLT] & w_ng) |
                             (instr[JEQ] & w_zr) |
                             (instr[JGT] & ~w_ng & ~w_zr));
        w_load_a = ~w_is_c | instr[DEST_A];
        w_load_d = w_is_c & instr[DEST_D];
        w_a_nxt  = w_is_c ? w_alu_out : {1'b0, instr[14:0]};
        w_pc_nxt = w_jump ? r_a[PC_W-1:0] : (r_pc + PC_ONE);
    end

    // Architectural registers and retire counter, updated on retirement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_d       <= '0;
            r_pc      <= '0;
            r_retired <= '0;
        end else if (w_fire) begin
            r_pc      <= w_pc_nxt;
            r_retired <= r_retired + CNT_ONE;
            if (w_load_a) r_a <= w_a_nxt;
            if (w_load_d) r_d <= w_alu_out;
        end
    end

`ifdef HACK_CPU_HALT_EN
    logic r_halted;

    // Sticky halt on a taken jump to the instruction's own address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_halted <= 1'b0;
        end else if (w_fire && w_jump && (r_a[PC_W-1:0] == r_pc)) begin
            r_halted <= 1'b1;
        end
    end

    assign w_halt_blk = r_halted;
    assign halted     = r_halted;
`else
    assign w_halt_blk = 1'b0;
`endif

    assign outM     = w_alu_out;
    assign writeM   = w_fire & w_is_c & instr[DEST_M];
    assign addressM = r_a[PC_W-1:0];
    assign pc       = r_pc;
    assign retired  = r_retired;

endmodule

// File: tb/tb_hack_cpu.sv
module tb_hack_cpu;
    import hack_pkg::*;

`ifdef HACK_CPU_HALT_EN
    localparam bit HALT = 1'b1;
`else
    localparam bit HALT = 1'b0;
`endif

    localparam logic [5:0] C_A      = 6'b110000;
    localparam logic [5:0] C_MINUS1 = 6'b111010;
    localparam logic [5:0] C_YPLUS1 = 6'b110111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic        instr_valid = 1'b0;
    logic [15:0] inM = 16'h0000;
    logic [15:0] outM;
    logic        writeM;
    logic [14:0] addressM;
    logic [14:0] pc;
    logic [15:0] retired;
`ifdef HACK_CPU_HALT_EN
    logic        halted;
`endif

    int nvec = 0;
    int nerr = 0;

    // Reference machine state
    logic [15:0] m_a, m_d, m_ret;
    logic [14:0] m_pc;
    logic        m_halt;

    hack_cpu #(.PC_W(15), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .inM(inM), .outM(outM), .writeM(writeM), .addressM(addressM),
        .pc(pc), .retired(retired)
`ifdef HACK_CPU_HALT_EN
        , .halted(halted)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] cinst(input logic a, input logic [5:0] c,
                                          input logic [2:0] d, input logic [2:0] j);
        return {3'b111, a, c, d, j};
    endfunction

    // Hack comp semantics: zero/negate operands, add or AND, negate result.
    function automatic logic [15:0] ref_alu(input logic [15:0] x, input logic [15:0] y,
                                            input logic [5:0] c);
        int sx, sy;
        logic [15:0] r;
        sx = c[5] ? 0 : int'(x);
        if (c[4]) sx = 65535 - sx;
        sy = c[3] ? 0 : int'(y);
        if (c[2]) sy = 65535 - sy;
        if (c[1]) r = 16'((sx + sy) % 65536);
        else      r = 16'(sx) & 16'(sy);
        if (c[0]) r = 16'(65535 - int'(r));
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_a = 0; m_d = 0; m_pc = 0; m_ret = 0; m_halt = 0;
    endtask

    task automatic peek(input logic [15:0] ins, input logic [15:0] m);
        instr = ins; instr_valid = 1'b1; inM = m;
        #1;
    endtask

    // Drive one cycle, check combinational and registered outputs against
    // the model, clock it, then advance the model.
    task automatic apply(input logic [15:0] ins, input logic v, input logic [15:0] m);
        logic [15:0] y, o;
        logic        isc, fire, jmp;
        logic signed [15:0] so;
        instr = ins; instr_valid = v; inM = m;
        #2;
        isc  = ins[15];
        fire = v && !m_halt;
        y    = ins[12] ? m : m_a;
        o    = ref_alu(m_d, y, ins[11:6]);
        so   = o;
        jmp  = isc && ((ins[2] && so < 0) || (ins[1] && so == 0) || (ins[0] && so > 0));
        if (isc) chk("outM", 32'(outM), 32'(o));
        chk("writeM", 32'(writeM), 32'(fire && isc && ins[3]));
        chk("addressM", 32'(addressM), 32'(m_a[14:0]));
        chk("pc", 32'(pc), 32'(m_pc));
        chk("retired", 32'(retired), 32'(m_ret));
`ifdef HACK_CPU_HALT_EN
        chk("halted", 32'(halted), 32'(m_halt));
`endif
        @(posedge clk);
        #1;
        if (fire) begin
            if (HALT && jmp && m_a[14:0] == m_pc) m_halt = 1'b1;
            m_pc  = jmp ? m_a[14:0] : m_pc + 15'd1;
            m_ret = m_ret + 16'd1;
            if (!isc) m_a = {1'b0, ins[14:0]};
            else begin
                if (ins[4]) m_d = o;
                if (ins[5]) m_a = o;
            end
        end
    endtask

    // Asynchronous reset asserted mid-cycle with a valid instruction present.
    task automatic do_reset();
        instr = 16'h1234; instr_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        instr_valid = 1'b0;
        #1;
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_writeM", 32'(writeM), 32'd0);
        chk("rst_addressM", 32'(addressM), 32'd0);
`ifdef HACK_CPU_HALT_EN
        chk("rst_halted", 32'(halted), 32'd0);
`endif
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [14:0] s_pc;
        logic [15:0] s_ret;
        model_reset();
        @(posedge clk);
        #1;
        chk("init_pc", 32'(pc), 32'd0);
        chk("init_retired", 32'(retired), 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // @5; D=A; @7; D=D+A; M=D
        apply(16'd5, 1'b1, 16'h0);
        apply(cinst(1'b0, C_A, 3'b010, 3'b000), 1'b1, 16'h0);
        apply(16'd7, 1'b1, 16'h0);
        apply(cinst(1'b0, COMP_XPLUSY, 3'b010, 3'b000), 1'b1, 16'h0);
        peek(cinst(1'b0, COMP_X, 3'b001, 3'b000), 16'h0);
        chk("md_addressM", 32'(addressM), 32'd7);
        chk("md_outM", 32'(outM), 32'd12);
        chk("md_writeM", 32'(writeM), 32'd1);
        apply(cinst(1'b0, COMP_X, 3'b001, 3'b000), 1'b1, 16'h0);
        chk("md_retired", 32'(retired), 32'd5);

        do_reset();

        // @10; AM=M+1 with inM=0x7FFF
        apply(16'd10, 1'b1, 16'h0);
        peek(cinst(1'b1, C_YPLUS1, 3'b101, 3'b000), 16'h7FFF);
        chk("am_outM", 32'(outM), 32'h8000);
        chk("am_writeM", 32'(writeM), 32'd1);
        chk("am_addressM", 32'(addressM), 32'd10);
        apply(cinst(1'b1, C_YPLUS1, 3'b101, 3'b000), 1'b1, 16'h7FFF);
        chk("am_next_addressM", 32'(addressM), 32'd0);

        // D=-1; @20; D;JLT taken
        apply(cinst(1'b0, C_MINUS1, 3'b010, 3'b000), 1'b1, 16'h0);
        apply(16'd20, 1'b1, 16'h0);
        apply(cinst(1'b0, COMP_X, 3'b000, 3'b100), 1'b1, 16'h0);
        chk("jlt_taken_pc", 32'(pc), 32'd20);
        // D=0; @20; D;JLT not taken
        apply(cinst(1'b0, COMP_ZERO, 3'b010, 3'b000), 1'b1, 16'h0);
        apply(16'd20, 1'b1, 16'h0);
        s_pc = pc;
        apply(cinst(1'b0, COMP_X, 3'b000, 3'b100), 1'b1, 16'h0);
        chk("jlt_fall_pc", 32'(pc), 32'(s_pc + 15'd1));
        apply(cinst(1'b0, COMP_ZERO, 3'b000, 3'b111), 1'b1, 16'h0);
        chk("jmp_pc", 32'(pc), 32'd20);

        // Stall for three cycles
        apply(16'd33, 1'b1, 16'h0);
        apply(cinst(1'b0, COMP_ONE, 3'b010, 3'b000), 1'b1, 16'h0);
        s_pc = pc; s_ret = retired;
        for (int i = 0; i < 3; i++)
            apply(cinst(1'b0, COMP_ONE, 3'b111, 3'b111), 1'b0, 16'($urandom));
        chk("stall_pc", 32'(pc), 32'(s_pc));
        chk("stall_retired", 32'(retired), 32'(s_ret));
        chk("stall_addressM", 32'(addressM), 32'd33);
        apply(cinst(1'b0, COMP_X, 3'b001, 3'b000), 1'b1, 16'h0);
        apply(cinst(1'b0, COMP_XPLUSY, 3'b010, 3'b000), 1'b1, 16'h0);

        // Randomized program
        for (int i = 0; i < 400; i++)
            apply(16'($urandom), ($urandom_range(0, 9) != 0), 16'($urandom));

`ifdef HACK_CPU_HALT_EN
        do_reset();
        for (int i = 0; i < 3; i++) apply(16'd0, 1'b1, 16'h0);
        apply(16'd4, 1'b1, 16'h0);
        apply(cinst(1'b0, COMP_ZERO, 3'b000, 3'b111), 1'b1, 16'h0);
        chk("halt_set", 32'(halted), 32'd1);
        chk("halt_pc", 32'(pc), 32'd4);
        for (int i = 0; i < 4; i++)
            apply(cinst(1'b0, COMP_ONE, 3'b111, 3'b000), 1'b1, 16'($urandom));
        chk("halt_frozen_pc", 32'(pc), 32'd4);
        chk("halt_frozen_retired", 32'(retired), 32'd5);
        do_reset();
        apply(16'd9, 1'b1, 16'h0);
        chk("halt_cleared_pc", 32'(pc), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
